fifo_read_stream: RTL and testbench
===================================

Name: fifo_read_stream

Overview:
- Read-side drain engine for the async FIFO, clocked in the read domain.
- Pops a programmed burst of words from the FIFO read port (first-word-fall-through: read data valid whenever not empty) and presents them on a valid/ready stream with a last-word marker.
- All stream outputs are registered. A 2-entry internal buffer absorbs downstream backpressure, so there is no combinational path from stream_ready_i to read_increment_o.

Parameters:
- data_size, 8, width of FIFO data word and stream data.
- count_size, 8, width of burst length and word counters.

Ports:
- read_clk_i  input  1  read-domain clock.
- read_reset_n_i  input  1  reset: asynchronous assertion, active-low.
- enable_i  input  1  start request, sampled in IDLE.
- burst_length_i  input  count_size  words per burst, latched at start; 0 is invalid.
- read_empty_i  input  1  FIFO empty flag.
- read_data_i  input  data_size  FIFO head word, valid when read_empty_i=0.
- read_increment_o  output  1  pop strobe to FIFO.
- stream_valid_o  output  1  stream data valid.
- stream_data_o  output  data_size  stream data.
- stream_last_o  output  1  marks final word of burst, qualified by stream_valid_o.
- stream_ready_i  input  1  downstream accept.
- busy_o  output  1  high outside IDLE.
- done_o  output  1  one-cycle pulse when burst fully accepted.
- word_count_o  output  count_size  words accepted downstream in the current burst.

Behaviour:
- Reset (read_reset_n_i=0, asynchronous): state=IDLE; buffer occupancy=0; pop counter=0; word_count_o=0; read_increment_o=0; stream_valid_o=0; stream_data_o=0; stream_last_o=0; busy_o=0; done_o=0.
- Reset mid-burst: words already popped and held in the buffer are discarded. No recovery.
- States:
  - IDLE: if enable_i=1 and burst_length_i!=0, latch the length, clear the pop counter and word_count_o, and go to RUN next cycle. Length 0 is ignored; stay in IDLE.
  - RUN: pops proceed. When the pop counter reaches the length (after the last pop), go to DRAIN.
  - DRAIN: no pops. When buffer occupancy reaches 0, go to IDLE and pulse done_o for 1 cycle, coincident with entry to IDLE.
- enable_i and burst_length_i are ignored outside IDLE. Deasserting enable_i mid-burst does not abort the burst.
- Pop rule (combinational from registers only): read_increment_o = (state==RUN) & ~read_empty_i & (occupancy<2) & (pop counter < length).
  - Never asserted while read_empty_i=1.
  - The popped word is read_data_i in that same cycle.
  - It is written into the buffer with last tag = (pop counter == length-1).
- Buffer is a 2-entry FIFO; the head drives stream_valid_o, stream_data_o and stream_last_o from registers.
  - Latency: a pop in cycle N gives stream_valid_o=1 in cycle N+1 when the buffer was empty.
  - Transfer occurs when stream_valid_o & stream_ready_i. On transfer, word_count_o increments (wraps at 2^count_size, unreachable with a valid length).
  - Simultaneous pop and transfer: occupancy unchanged and ordering preserved. A pop at occupancy 1 with transfer is allowed.
- Throughput: with ready held high and the FIFO non-empty, sustains 1 word per clock after a 1-cycle startup.
- Stream rules:
  - Once stream_valid_o=1, stream_data_o and stream_last_o are stable until the transfer.
  - stream_valid_o never drops without a transfer.
  - Exactly one stream_last_o transfer per burst.
- FIFO going empty mid-burst: pops stall and the stream drains the buffer. Resumes as soon as read_empty_i=0; no timeout.
- word_count_o holds its final value in IDLE until the next start.

Test Plan:
- Reset/idle: hold read_reset_n_i=0 with FIFO non-empty and enable_i=1 -> all outputs 0, no pops. Release with burst_length_i=0 -> remains IDLE, busy_o=0.
- Basic burst: FIFO preloaded with 0x11..0x14, burst_length_i=4, stream_ready_i=1 -> exactly 4 pops on consecutive cycles; stream carries 0x11,0x12,0x13,0x14 on consecutive cycles, stream_last_o only with 0x14; done_o pulses once; word_count_o=4.
- Backpressure: burst_length_i=6, ready pattern 1,0,0,1,0,1,1,1... -> occupancy never exceeds 2; no pop while occupancy=2; data order intact; held data stable during ready=0.
- Underflow stall: burst_length_i=5 with only 2 words present, 3 more written 20 cycles later -> read_increment_o=0 while empty; stream idles after 2 words; burst completes with last on word 5.
- Overlength FIFO: 10 words present, burst_length_i=3 -> exactly 3 pops; 7 words remain (read_empty_i stays 0); second enable_i start pops the next 3 in order.
- Reset mid-burst: assert reset with 2 words buffered, stream_ready_i=0 -> outputs clear immediately (asynchronous). After release, state is IDLE and a new burst starts cleanly with word_count_o=0.

Source files
------------

// File: rtl/fifo_read_stream.sv
// Read-side burst drain engine: pops FIFO words into a 2-entry skid buffer and streams them out with a last marker.
// Latency: pop in cycle N is presented on the stream in cycle N+1 when the buffer was empty; 1 word/clock sustained.
// Backpressure: stream_ready_i only affects registered occupancy, so pops stall at 2 buffered words with no ready->pop path.
module fifo_read_stream #(
    parameter int data_size  = 8,
    parameter int count_size = 8
) (
    input  logic                  read_clk_i,
    input  logic                  read_reset_n_i,
    input  logic                  enable_i,
    input  logic [count_size-1:0] burst_length_i,
    input  logic                  read_empty_i,
    input  logic [data_size-1:0]  read_data_i,
    output logic                  read_increment_o,
    output logic                  stream_valid_o,
    output logic [data_size-1:0]  stream_data_o,
    output logic                  stream_last_o,
    input  logic                  stream_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [count_size-1:0] word_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [count_size-1:0] CNT_ONE = {{(count_size-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [count_size-1:0] length_q;
    logic [count_size-1:0] pop_count;
    logic [count_size-1:0] word_count_q;
    logic [1:0]            occ, occ_nxt;
    logic                  head_vld;
    logic [data_size-1:0]  head_dat, tail_dat;
    logic                  head_last, tail_last;
    logic                  done_q, done_nxt;

    logic pop;
    logic xfer;
    logic pop_last;
    logic start;

    // Pop decision uses registered state only; stream_ready_i never feeds it.
    assign pop      = (state == RUN) & ~read_empty_i & (occ < 2'd2) & (pop_count < length_q);
    assign xfer     = head_vld & stream_ready_i;
    assign pop_last = (pop_count == (length_q - CNT_ONE));
    assign start    = (state == IDLE) & enable_i & (burst_length_i != '0);

    always_comb begin
        state_nxt = state;
        occ_nxt   = occ;
        done_nxt  = 1'b0;

        case ({pop, xfer})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (pop && pop_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Finish on the cycle the final buffered word is accepted.
                if (occ_nxt == 2'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            state        <= IDLE;
            occ          <= 2'd0;
            head_vld     <= 1'b0;
            done_q       <= 1'b0;
            length_q     <= '0;
            pop_count    <= '0;
            word_count_q <= '0;
        end else begin
            state    <= state_nxt;
            occ      <= occ_nxt;
            head_vld <= (occ_nxt != 2'd0);
            done_q   <= done_nxt;
            if (start) begin
                length_q     <= burst_length_i;
                pop_count    <= '0;
                word_count_q <= '0;
            end else begin
                if (pop) begin
                    pop_count <= pop_count + CNT_ONE;
                end
                if (xfer) begin
                    word_count_q <= word_count_q + CNT_ONE;
                end
            end
        end
    end

    // Head/tail shift buffer: head always holds the oldest word.
    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            head_dat  <= '0;
            head_last <= 1'b0;
            tail_dat  <= '0;
            tail_last <= 1'b0;
        end else begin
            case ({pop, xfer})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_dat  <= read_data_i;
                        head_last <= pop_last;
                    end else begin
                        tail_dat  <= read_data_i;
                        tail_last <= pop_last;
                    end
                end
                2'b01: begin
                    head_dat  <= tail_dat;
                    head_last <= tail_last;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_dat  <= read_data_i;
                        head_last <= pop_last;
                    end else begin
                        head_dat  <= tail_dat;
                        head_last <= tail_last;
                        tail_dat  <= read_data_i;
                        tail_last <= pop_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign read_increment_o = pop;
    assign stream_valid_o   = head_vld;
    assign stream_data_o    = head_dat;
    assign stream_last_o    = head_last;
    assign busy_o           = (state != IDLE);
    assign done_o           = done_q;
    assign word_count_o     = word_count_q;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: behavioural FIFO model, scoreboard of popped words, table of burst scenarios.
module tb_fifo_read_stream;

    logic       read_clk_i;
    logic       read_reset_n_i;
    logic       enable_i;
    logic [7:0] burst_length_i;
    logic       read_empty_i;
    logic [7:0] read_data_i;
    logic       read_increment_o;
    logic       stream_valid_o;
    logic [7:0] stream_data_o;
    logic       stream_last_o;
    logic       stream_ready_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] word_count_o;

    fifo_read_stream #(.data_size(8), .count_size(8)) dut (
        .read_clk_i       (read_clk_i),
        .read_reset_n_i   (read_reset_n_i),
        .enable_i         (enable_i),
        .burst_length_i   (burst_length_i),
        .read_empty_i     (read_empty_i),
        .read_data_i      (read_data_i),
        .read_increment_o (read_increment_o),
        .stream_valid_o   (stream_valid_o),
        .stream_data_o    (stream_data_o),
        .stream_last_o    (stream_last_o),
        .stream_ready_i   (stream_ready_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .word_count_o     (word_count_o)
    );

    initial read_clk_i = 1'b0;
    always #5 read_clk_i = ~read_clk_i;

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } exp_t;

    typedef struct {
        int          len;
        int          preload;
        int          late;
        logic [15:0] rdy;
        int          exp_done_cyc;
        int          exp_remain;
    } row_t;

    exp_t       sb[$];
    logic [7:0] fifo_q[$];
    logic [7:0] next_val;

    int   checks;
    int   failures;
    int   pops_row, xfers_row, dones_row, lasts_row, len_cur, occ_model, done_cyc;
    logic prev_hold;
    logic [7:0] prev_dat;
    logic prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo_pins();
        read_empty_i = (fifo_q.size() == 0);
        read_data_i  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) begin
            fifo_q.push_back(next_val);
            next_val = next_val + 8'd1;
        end
        drive_fifo_pins();
    endtask

    // One clock: sample just after the negedge, model the posedge, return at the next negedge.
    task automatic cycle();
        logic p, x;
        exp_t e;
        #1;
        p = read_increment_o;
        x = stream_valid_o & stream_ready_i;
        if (read_empty_i) chk("pop_while_empty", {31'd0, p}, 32'd0);
        if (p) chk("pop_at_full", (occ_model < 2) ? 32'd1 : 32'd0, 32'd1);
        if (prev_hold) begin
            chk("hold_valid", {31'd0, stream_valid_o}, 32'd1);
            chk("hold_data", {24'd0, stream_data_o}, {24'd0, prev_dat});
            chk("hold_last", {31'd0, stream_last_o}, {31'd0, prev_last});
        end
        if (busy_o) chk("word_count", {24'd0, word_count_o}, xfers_row);
        if (done_o) begin
            if (dones_row == 0) done_cyc = -2;
            dones_row++;
        end
        if (x) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("stream_data", {24'd0, stream_data_o}, {24'd0, e.dat});
                chk("stream_last", {31'd0, stream_last_o}, {31'd0, e.last});
            end
            if (stream_last_o) lasts_row++;
        end
        prev_hold = stream_valid_o & ~stream_ready_i;
        prev_dat  = stream_data_o;
        prev_last = stream_last_o;
        @(posedge read_clk_i);
        if (p) begin
            e.dat  = fifo_q.pop_front();
            e.last = (pops_row == len_cur - 1);
            sb.push_back(e);
            pops_row++;
            occ_model++;
        end
        if (x) begin
            occ_model--;
            xfers_row++;
        end
        chk("occupancy_bound", (occ_model <= 2) ? 32'd1 : 32'd0, 32'd1);
        @(negedge read_clk_i);
        drive_fifo_pins();
    endtask

    task automatic clear_row(input int len);
        pops_row  = 0;
        xfers_row = 0;
        dones_row = 0;
        lasts_row = 0;
        len_cur   = len;
        done_cyc  = -1;
    endtask

    task automatic run_burst(input row_t r);
        int i;
        clear_row(r.len);
        push_words(r.preload);
        enable_i       = 1'b1;
        burst_length_i = r.len[7:0];
        stream_ready_i = r.rdy[0];
        cycle();
        // Inputs below must be ignored once the burst is running.
        enable_i       = 1'b1;
        burst_length_i = 8'd0;
        i = 1;
        while (dones_row == 0 && i < 200) begin
            if (r.late > 0 && i == 19) begin
                chk("stall_word_count", {24'd0, word_count_o}, r.preload);
                chk("stall_valid", {31'd0, stream_valid_o}, 32'd0);
            end
            if (r.late > 0 && i == 20) push_words(r.late);
            stream_ready_i = (i < 16) ? r.rdy[i] : 1'b1;
            cycle();
            if (done_cyc == -2) done_cyc = i;
            i++;
        end
        enable_i = 1'b0;
        if (dones_row == 0) chk("done_timeout", 32'd0, 32'd1);
        stream_ready_i = 1'b1;
        repeat (2) cycle();
        chk("pops", pops_row, r.len);
        chk("fifo_remain", fifo_q.size(), r.exp_remain);
        chk("final_word_count", {24'd0, word_count_o}, r.len);
        chk("busy_after", {31'd0, busy_o}, 32'd0);
        chk("done_pulses", dones_row, 32'd1);
        chk("last_count", lasts_row, 32'd1);
        chk("sb_empty", sb.size(), 32'd0);
        if (r.exp_done_cyc >= 0) chk("done_cycle", done_cyc, r.exp_done_cyc);
    endtask

    row_t rows[6];
    row_t rr;

    initial begin
        rows[0] = '{len: 4, preload: 4,  late: 0, rdy: 16'hFFFF, exp_done_cyc: 6,  exp_remain: 0};
        rows[1] = '{len: 6, preload: 6,  late: 0, rdy: 16'hFFE9, exp_done_cyc: -1, exp_remain: 0};
        rows[2] = '{len: 5, preload: 2,  late: 3, rdy: 16'hFFFF, exp_done_cyc: -1, exp_remain: 0};
        rows[3] = '{len: 3, preload: 10, late: 0, rdy: 16'hFFFF, exp_done_cyc: 5,  exp_remain: 7};
        rows[4] = '{len: 3, preload: 0,  late: 0, rdy: 16'hFFFF, exp_done_cyc: 5,  exp_remain: 4};
        rows[5] = '{len: 1, preload: 0,  late: 0, rdy: 16'hFFFF, exp_done_cyc: 3,  exp_remain: 3};

        checks    = 0;
        failures  = 0;
        occ_model = 0;
        prev_hold = 1'b0;
        prev_dat  = 8'h00;
        prev_last = 1'b0;
        next_val  = 8'h01;
        clear_row(4);
        read_reset_n_i = 1'b0;
        enable_i       = 1'b1;
        burst_length_i = 8'd4;
        stream_ready_i = 1'b1;
        push_words(5);

        // Held in reset with a non-empty FIFO and enable high.
        @(negedge read_clk_i);
        repeat (3) cycle();
        #1;
        chk("rst_pop", {31'd0, read_increment_o}, 32'd0);
        chk("rst_valid", {31'd0, stream_valid_o}, 32'd0);
        chk("rst_data", {24'd0, stream_data_o}, 32'd0);
        chk("rst_last", {31'd0, stream_last_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_word_count", {24'd0, word_count_o}, 32'd0);

        // Zero length is ignored.
        @(negedge read_clk_i);
        burst_length_i = 8'd0;
        read_reset_n_i = 1'b1;
        repeat (5) cycle();
        chk("len0_busy", {31'd0, busy_o}, 32'd0);
        chk("len0_pops", pops_row, 32'd0);
        chk("len0_fifo", fifo_q.size(), 32'd5);
        enable_i = 1'b0;
        fifo_q.delete();
        drive_fifo_pins();
        next_val = 8'h11;

        for (int r = 0; r < 6; r++) begin
            run_burst(rows[r]);
        end

        // Reset mid-burst with two words buffered and the stream stalled.
        fifo_q.delete();
        next_val = 8'h40;
        clear_row(4);
        push_words(4);
        enable_i       = 1'b1;
        burst_length_i = 8'd4;
        stream_ready_i = 1'b0;
        cycle();
        enable_i = 1'b0;
        repeat (3) cycle();
        chk("mid_valid", {31'd0, stream_valid_o}, 32'd1);
        chk("mid_pops", pops_row, 32'd2);
        #2;
        read_reset_n_i = 1'b0;
        #1;
        chk("arst_valid", {31'd0, stream_valid_o}, 32'd0);
        chk("arst_data", {24'd0, stream_data_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_pop", {31'd0, read_increment_o}, 32'd0);
        chk("arst_word_count", {24'd0, word_count_o}, 32'd0);
        sb.delete();
        occ_model = 0;
        prev_hold = 1'b0;
        @(negedge read_clk_i);
        read_reset_n_i = 1'b1;
        cycle();
        chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
        rr = '{len: 2, preload: 0, late: 0, rdy: 16'hFFFF, exp_done_cyc: 4, exp_remain: 0};
        run_burst(rr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
